wb_retire_stage: RTL and testbench

Parametrised memory/writeback pipeline register and writeback stage for the pipelined hart. Captures one instruction per cycle from the memory stage and extracts and extends load data from the aligned dmem word. It selects the destination value, drives the register-file write port and the retire interface, and stops the pipeline after `ebreak` retires. It also counts retired instructions.

---
 rtl/wb_retire_stage_if.sv | 70 +++++++
 rtl/wb_retire_stage.sv | 152 +++++++++++++++
 tb/tb_wb_retire_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_stage_if.sv
// Memory-stage to writeback/retire bundle for wb_retire_stage.
// The slave modport is the stage itself; the master modport is whoever drives the memory-stage side.
interface wb_retire_stage_if #(
  parameter int CNT_WIDTH = 64
);
  logic                 i_valid;
  logic                 o_ready;
  logic [31:0]          i_inst;
  logic [31:0]          i_pc;
  logic [31:0]          i_next_pc;
  logic [31:0]          i_alu_result;
  logic [31:0]          i_uimm;
  logic [31:0]          i_dmem_rdata;
  logic [1:0]           i_mem_offset;
  logic [1:0]           i_load_size;
  logic                 i_load_unsigned;
  logic [1:0]           i_wb_sel;
  logic                 i_reg_write;
  logic [4:0]           i_rd_waddr;
  logic [4:0]           i_rs1_raddr;
  logic [4:0]           i_rs2_raddr;
  logic [31:0]          i_rs1_rdata;
  logic [31:0]          i_rs2_rdata;
  logic                 i_trap;
  logic                 i_halt;

  logic                 o_rf_wen;
  logic [4:0]           o_rf_waddr;
  logic [31:0]          o_rf_wdata;

  logic                 o_retire_valid;
  logic [31:0]          o_retire_inst;
  logic                 o_retire_trap;
  logic                 o_retire_halt;
  logic [4:0]           o_retire_rs1_raddr;
  logic [4:0]           o_retire_rs2_raddr;
  logic [31:0]          o_retire_rs1_rdata;
  logic [31:0]          o_retire_rs2_rdata;
  logic [4:0]           o_retire_rd_waddr;
  logic [31:0]          o_retire_rd_wdata;
  logic [31:0]          o_retire_pc;
  logic [31:0]          o_retire_next_pc;

  logic                 o_halted;
  logic [CNT_WIDTH-1:0] o_instret;

  modport slave (
    input  i_valid, i_inst, i_pc, i_next_pc, i_alu_result, i_uimm, i_dmem_rdata,
           i_mem_offset, i_load_size, i_load_unsigned, i_wb_sel, i_reg_write,
           i_rd_waddr, i_rs1_raddr, i_rs2_raddr, i_rs1_rdata, i_rs2_rdata,
           i_trap, i_halt,
    output o_ready, o_rf_wen, o_rf_waddr, o_rf_wdata,
           o_retire_valid, o_retire_inst, o_retire_trap, o_retire_halt,
           o_retire_rs1_raddr, o_retire_rs2_raddr, o_retire_rs1_rdata,
           o_retire_rs2_rdata, o_retire_rd_waddr, o_retire_rd_wdata,
           o_retire_pc, o_retire_next_pc, o_halted, o_instret
  );

  modport master (
    output i_valid, i_inst, i_pc, i_next_pc, i_alu_result, i_uimm, i_dmem_rdata,
           i_mem_offset, i_load_size, i_load_unsigned, i_wb_sel, i_reg_write,
           i_rd_waddr, i_rs1_raddr, i_rs2_raddr, i_rs1_rdata, i_rs2_rdata,
           i_trap, i_halt,
    input  o_ready, o_rf_wen, o_rf_waddr, o_rf_wdata,
           o_retire_valid, o_retire_inst, o_retire_trap, o_retire_halt,
           o_retire_rs1_raddr, o_retire_rs2_raddr, o_retire_rs1_rdata,
           o_retire_rs2_rdata, o_retire_rd_waddr, o_retire_rd_wdata,
           o_retire_pc, o_retire_next_pc, o_halted, o_instret
  );
endinterface

// File: rtl/wb_retire_stage.sv
// Memory/writeback pipeline register, load extraction, register-file write and retire port.
// Define WB_INSTRET_EN to build the retired-instruction counter; otherwise o_instret is tied to 0.
module wb_retire_stage #(
  parameter int CNT_WIDTH    = 64,
  parameter int HALT_ON_TRAP = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  wb_retire_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] alu;
    logic [31:0] uimm;
    logic [31:0] load;
    logic [31:0] pc4;
    logic [1:0]  wb_sel;
    logic        reg_write;
    logic [4:0]  rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        trap;
    logic        halt;
  } stage_t;

  state_e      state_q, state_d;
  stage_t      stage_q, stage_d;
  logic [15:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] rd_wdata;
  logic        ready;
  logic        halt_now;
  logic        accept;
  logic        rd_written;

  assign ready    = (state_q == ST_RUN);
  assign halt_now = stage_q.valid & (stage_q.halt | ((HALT_ON_TRAP != 0) & stage_q.trap));
  // The edge that moves us to HALTED must not capture a new instruction either.
  assign accept   = bus.i_valid & ready & ~halt_now;

  always_comb begin
    shifted  = 16'(bus.i_dmem_rdata >> {bus.i_mem_offset, 3'b000});
    load_ext = bus.i_dmem_rdata;
    case (bus.i_load_size)
      2'b00:   load_ext = {{24{~bus.i_load_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~bus.i_load_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_ext = bus.i_dmem_rdata;
    endcase
  end

  always_comb begin
    stage_d       = stage_q;
    stage_d.valid = 1'b0;
    state_d       = state_q;
    if (halt_now) begin
      state_d = ST_HALTED;
    end
    if (accept) begin
      stage_d.valid     = 1'b1;
      stage_d.inst      = bus.i_inst;
      stage_d.pc        = bus.i_pc;
      stage_d.next_pc   = bus.i_next_pc;
      stage_d.alu       = bus.i_alu_result;
      stage_d.uimm      = bus.i_uimm;
      stage_d.load      = load_ext;
      stage_d.pc4       = bus.i_pc + 32'd4;
      stage_d.wb_sel    = bus.i_wb_sel;
      stage_d.reg_write = bus.i_reg_write;
      stage_d.rd        = bus.i_rd_waddr;
      stage_d.rs1_addr  = bus.i_rs1_raddr;
      stage_d.rs2_addr  = bus.i_rs2_raddr;
      stage_d.rs1_data  = (bus.i_rs1_raddr == 5'd0) ? 32'd0 : bus.i_rs1_rdata;
      stage_d.rs2_data  = (bus.i_rs2_raddr == 5'd0) ? 32'd0 : bus.i_rs2_rdata;
      stage_d.trap      = bus.i_trap;
      stage_d.halt      = bus.i_halt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    case (stage_q.wb_sel)
      2'b00:   rd_wdata = stage_q.alu;
      2'b01:   rd_wdata = stage_q.load;
      2'b10:   rd_wdata = stage_q.pc4;
      default: rd_wdata = stage_q.uimm;
    endcase
  end

  assign rd_written = stage_q.reg_write & ~stage_q.trap;

  assign bus.o_ready            = ready;
  assign bus.o_halted           = (state_q == ST_HALTED);
  assign bus.o_rf_wen           = stage_q.valid & rd_written & (stage_q.rd != 5'd0);
  assign bus.o_rf_waddr         = stage_q.rd;
  assign bus.o_rf_wdata         = rd_wdata;
  assign bus.o_retire_valid     = stage_q.valid;
  assign bus.o_retire_inst      = stage_q.inst;
  assign bus.o_retire_trap      = stage_q.trap;
  assign bus.o_retire_halt      = stage_q.halt;
  assign bus.o_retire_rs1_raddr = stage_q.rs1_addr;
  assign bus.o_retire_rs2_raddr = stage_q.rs2_addr;
  assign bus.o_retire_rs1_rdata = stage_q.rs1_data;
  assign bus.o_retire_rs2_rdata = stage_q.rs2_data;
  assign bus.o_retire_rd_waddr  = rd_written ? stage_q.rd : 5'd0;
  assign bus.o_retire_rd_wdata  = rd_wdata;
  assign bus.o_retire_pc        = stage_q.pc;
  assign bus.o_retire_next_pc   = stage_q.next_pc;

`ifdef WB_INSTRET_EN
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (stage_q.valid) begin
      instret_d = instret_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.o_instret = instret_q;
`else
  assign bus.o_instret = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed bench for wb_retire_stage: default instance plus a HALT_ON_TRAP=1, CNT_WIDTH=4 instance.
module tb_wb_retire_stage;

`ifdef WB_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_retire_stage_if #(.CNT_WIDTH(64)) bus_a ();
  wb_retire_stage_if #(.CNT_WIDTH(4))  bus_b ();

  wb_retire_stage #(.CNT_WIDTH(64), .HALT_ON_TRAP(0)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  wb_retire_stage #(.CNT_WIDTH(4), .HALT_ON_TRAP(1)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    bus_a.i_valid = 1'b0;         bus_a.i_inst = 32'd0;        bus_a.i_pc = 32'd0;
    bus_a.i_next_pc = 32'd0;      bus_a.i_alu_result = 32'd0;  bus_a.i_uimm = 32'd0;
    bus_a.i_dmem_rdata = 32'd0;   bus_a.i_mem_offset = 2'd0;   bus_a.i_load_size = 2'd0;
    bus_a.i_load_unsigned = 1'b0; bus_a.i_wb_sel = 2'd0;       bus_a.i_reg_write = 1'b0;
    bus_a.i_rd_waddr = 5'd0;      bus_a.i_rs1_raddr = 5'd0;    bus_a.i_rs2_raddr = 5'd0;
    bus_a.i_rs1_rdata = 32'd0;    bus_a.i_rs2_rdata = 32'd0;   bus_a.i_trap = 1'b0;
    bus_a.i_halt = 1'b0;
  endtask

  task automatic clear_b();
    bus_b.i_valid = 1'b0;         bus_b.i_inst = 32'd0;        bus_b.i_pc = 32'd0;
    bus_b.i_next_pc = 32'd0;      bus_b.i_alu_result = 32'd0;  bus_b.i_uimm = 32'd0;
    bus_b.i_dmem_rdata = 32'd0;   bus_b.i_mem_offset = 2'd0;   bus_b.i_load_size = 2'd0;
    bus_b.i_load_unsigned = 1'b0; bus_b.i_wb_sel = 2'd0;       bus_b.i_reg_write = 1'b0;
    bus_b.i_rd_waddr = 5'd0;      bus_b.i_rs1_raddr = 5'd0;    bus_b.i_rs2_raddr = 5'd0;
    bus_b.i_rs1_rdata = 32'd0;    bus_b.i_rs2_rdata = 32'd0;   bus_b.i_trap = 1'b0;
    bus_b.i_halt = 1'b0;
  endtask

  // Valid ALU write on instance A.
  task automatic alu_a(input logic [4:0] rd, input logic [31:0] val);
    clear_a();
    bus_a.i_valid = 1'b1; bus_a.i_reg_write = 1'b1; bus_a.i_rd_waddr = rd;
    bus_a.i_wb_sel = 2'b00; bus_a.i_alu_result = val;
  endtask

  // Valid load on instance A.
  task automatic load_a(input logic [1:0] size, input logic uns, input logic [1:0] off,
                        input logic [31:0] rdata);
    clear_a();
    bus_a.i_valid = 1'b1; bus_a.i_reg_write = 1'b1; bus_a.i_rd_waddr = 5'd10;
    bus_a.i_wb_sel = 2'b01; bus_a.i_load_size = size; bus_a.i_load_unsigned = uns;
    bus_a.i_mem_offset = off; bus_a.i_dmem_rdata = rdata;
  endtask

  initial begin
    clear_a();
    clear_b();
    rst_b = 1'b1;

    // Reset, with a valid instruction presented during reset.
    rst_a = 1'b1;
    alu_a(5'd9, 32'hDEAD_BEEF);
    tick();
    tick();
    check_b("reset_retire_valid", bus_a.o_retire_valid, 1'b0);
    check_b("reset_rf_wen", bus_a.o_rf_wen, 1'b0);
    check_w("reset_rf_wdata", bus_a.o_rf_wdata, 32'd0);
    check_b("reset_halted", bus_a.o_halted, 1'b0);
    check_b("reset_ready", bus_a.o_ready, 1'b1);
    check_w("reset_instret", 32'(bus_a.o_instret), 32'd0);

    rst_a = 1'b0;
    clear_a();
    tick();
    check_b("post_reset_ready", bus_a.o_ready, 1'b1);
    check_b("rst_valid_no_retire", bus_a.o_retire_valid, 1'b0);

    // ALU writeback.
    alu_a(5'd5, 32'h0000_1234);
    bus_a.i_pc = 32'h0000_0100; bus_a.i_next_pc = 32'h0000_0104; bus_a.i_inst = 32'h0000_0033;
    tick();
    check_b("alu_rf_wen", bus_a.o_rf_wen, 1'b1);
    check_w("alu_rf_waddr", 32'(bus_a.o_rf_waddr), 32'd5);
    check_w("alu_rf_wdata", bus_a.o_rf_wdata, 32'h0000_1234);
    check_b("alu_retire_valid", bus_a.o_retire_valid, 1'b1);
    check_w("alu_retire_rd", 32'(bus_a.o_retire_rd_waddr), 32'd5);
    check_w("alu_retire_pc", bus_a.o_retire_pc, 32'h0000_0100);
    check_w("alu_retire_next_pc", bus_a.o_retire_next_pc, 32'h0000_0104);
    check_w("alu_retire_inst", bus_a.o_retire_inst, 32'h0000_0033);

    // Loads.
    load_a(2'b00, 1'b0, 2'd3, 32'h80FF_0011);
    tick();
    check_w("lb_off3", bus_a.o_rf_wdata, 32'hFFFF_FF80);
    check_w("instret_after_1", 32'(bus_a.o_instret), INSTRET_ON ? 32'd1 : 32'd0);
    load_a(2'b00, 1'b1, 2'd3, 32'h80FF_0011);
    tick();
    check_w("lbu_off3", bus_a.o_rf_wdata, 32'h0000_0080);
    load_a(2'b01, 1'b0, 2'd2, 32'h80FF_0011);
    tick();
    check_w("lh_off2", bus_a.o_rf_wdata, 32'hFFFF_80FF);
    load_a(2'b10, 1'b0, 2'd0, 32'h1234_5678);
    tick();
    check_w("lw_off0", bus_a.o_rf_wdata, 32'h1234_5678);

    // JAL at the top of the address space: PC+4 wraps.
    clear_a();
    bus_a.i_valid = 1'b1; bus_a.i_reg_write = 1'b1; bus_a.i_rd_waddr = 5'd1;
    bus_a.i_wb_sel = 2'b10; bus_a.i_pc = 32'hFFFF_FFFC;
    tick();
    check_w("jal_wrap_wdata", bus_a.o_rf_wdata, 32'h0000_0000);
    check_b("jal_rf_wen", bus_a.o_rf_wen, 1'b1);

    // LUI to x0, with rs1 addr 0 carrying junk data.
    clear_a();
    bus_a.i_valid = 1'b1; bus_a.i_reg_write = 1'b1; bus_a.i_rd_waddr = 5'd0;
    bus_a.i_wb_sel = 2'b11; bus_a.i_uimm = 32'hABCD_E000;
    bus_a.i_rs1_raddr = 5'd0; bus_a.i_rs1_rdata = 32'h1111_1111;
    bus_a.i_rs2_raddr = 5'd7; bus_a.i_rs2_rdata = 32'h0000_0055;
    tick();
    check_b("x0_rf_wen", bus_a.o_rf_wen, 1'b0);
    check_w("x0_retire_rd", 32'(bus_a.o_retire_rd_waddr), 32'd0);
    check_b("x0_retire_valid", bus_a.o_retire_valid, 1'b1);
    check_w("lui_rd_wdata", bus_a.o_retire_rd_wdata, 32'hABCD_E000);
    check_w("rs1_zero_data", bus_a.o_retire_rs1_rdata, 32'd0);
    check_w("rs2_data", bus_a.o_retire_rs2_rdata, 32'h0000_0055);
    check_w("rs2_addr", 32'(bus_a.o_retire_rs2_raddr), 32'd7);

    // Trapped misaligned half load.
    load_a(2'b01, 1'b0, 2'd1, 32'h1234_5678);
    bus_a.i_rd_waddr = 5'd3; bus_a.i_trap = 1'b1;
    tick();
    check_b("trap_retire_valid", bus_a.o_retire_valid, 1'b1);
    check_b("trap_retire_trap", bus_a.o_retire_trap, 1'b1);
    check_b("trap_rf_wen", bus_a.o_rf_wen, 1'b0);
    check_w("trap_retire_rd", 32'(bus_a.o_retire_rd_waddr), 32'd0);
    check_w("instret_after_7", 32'(bus_a.o_instret), INSTRET_ON ? 32'd7 : 32'd0);

    clear_a();
    tick();
    check_b("bubble_retire_valid", bus_a.o_retire_valid, 1'b0);
    check_b("trap_no_halt_a", bus_a.o_halted, 1'b0);
    check_w("instret_after_8", 32'(bus_a.o_instret), INSTRET_ON ? 32'd8 : 32'd0);

    // ebreak followed by three adds.
    clear_a();
    bus_a.i_valid = 1'b1; bus_a.i_halt = 1'b1;
    tick();
    check_b("ebreak_retire_valid", bus_a.o_retire_valid, 1'b1);
    check_b("ebreak_retire_halt", bus_a.o_retire_halt, 1'b1);
    check_b("ebreak_halted_still0", bus_a.o_halted, 1'b0);
    for (int i = 0; i < 3; i++) begin
      alu_a(5'd6, 32'h0000_0077);
      tick();
      check_b("halted_no_retire", bus_a.o_retire_valid, 1'b0);
      check_b("halted_no_wen", bus_a.o_rf_wen, 1'b0);
      check_b("halted_flag", bus_a.o_halted, 1'b1);
      check_b("halted_ready", bus_a.o_ready, 1'b0);
    end
    check_w("instret_after_ebreak", 32'(bus_a.o_instret), INSTRET_ON ? 32'd9 : 32'd0);

    // Reset leaves HALTED and clears the counter.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    clear_a();
    check_b("rerst_halted", bus_a.o_halted, 1'b0);
    check_b("rerst_ready", bus_a.o_ready, 1'b1);
    check_w("rerst_instret", 32'(bus_a.o_instret), 32'd0);

    // Ten back-to-back retires.
    for (int i = 0; i < 10; i++) begin
      alu_a(5'd2, 32'(i));
      tick();
      check_w("b2b_wdata", bus_a.o_rf_wdata, 32'(i));
    end
    clear_a();
    tick();
    check_w("instret_10", 32'(bus_a.o_instret), INSTRET_ON ? 32'd10 : 32'd0);

    // Instance B: halt on trap, 4-bit counter.
    rst_b = 1'b0;
    clear_b();
    bus_b.i_valid = 1'b1; bus_b.i_trap = 1'b1; bus_b.i_reg_write = 1'b1; bus_b.i_rd_waddr = 5'd4;
    tick();
    check_b("b_trap_retire", bus_b.o_retire_valid, 1'b1);
    check_b("b_trap_halted0", bus_b.o_halted, 1'b0);
    check_b("b_trap_rf_wen", bus_b.o_rf_wen, 1'b0);
    clear_b();
    bus_b.i_valid = 1'b1;
    tick();
    check_b("b_trap_halted1", bus_b.o_halted, 1'b1);
    check_b("b_trap_ready0", bus_b.o_ready, 1'b0);
    check_b("b_no_retire", bus_b.o_retire_valid, 1'b0);

    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    for (int i = 0; i < 17; i++) begin
      clear_b();
      bus_b.i_valid = 1'b1; bus_b.i_reg_write = 1'b1; bus_b.i_rd_waddr = 5'd8;
      tick();
    end
    clear_b();
    tick();
    check_w("b_instret_wrap", 32'(bus_b.o_instret), INSTRET_ON ? 32'd1 : 32'd0);
    check_b("b_running", bus_b.o_halted, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
